// File: rtl/ddr_cmd_encoder.sv
// ddr_cmd_encoder
// Controller-side DDR4 command issuer. Accepts abstract requests over a
// valid/ready handshake, tracks open/closed state per bank, holds each
// request until the global timing gaps allow it, then drives one registered
// command cycle on the DDR4 command pins.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_cmd                  1=ACT 2=RD 3=RDA 4=WR 5=WRA 6=PR 7=PRA 8=REF
//   req_bg, req_ba           target bank group / bank
//   req_addr                 row for ACT, column in [COLWIDTH-1:0] otherwise
//   act_n, cs_n, cke         DDR4 control pins (cs_n low only on issue cycle)
//   bg, ba, A                bank and address/command pins
//   err                      one-cycle pulse when a request is rejected
//   busy                     FSM not in IDLE
module ddr_cmd_encoder #(
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int TRCD      = 16,
    parameter int TRAS      = 39,
    parameter int TRP       = 16,
    parameter int TCCD      = 4,
    parameter int TRFC      = 260
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_cmd,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_addr,
    output logic                 act_n,
    output logic                 cs_n,
    output logic                 cke,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [ADDRWIDTH-1:0] A,
    output logic                 err,
    output logic                 busy
);

    localparam int BKW    = BGWIDTH + BAWIDTH;
    localparam int NBANKS = 1 << BKW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    localparam logic [3:0] CMD_ACT = 4'd1;
    localparam logic [3:0] CMD_RD  = 4'd2;
    localparam logic [3:0] CMD_RDA = 4'd3;
    localparam logic [3:0] CMD_WR  = 4'd4;
    localparam logic [3:0] CMD_WRA = 4'd5;
    localparam logic [3:0] CMD_PR  = 4'd6;
    localparam logic [3:0] CMD_PRA = 4'd7;
    localparam logic [3:0] CMD_REF = 4'd8;

    localparam int W_RCD = $clog2(TRCD + 2);
    localparam int W_RAS = $clog2(TRAS + 2);
    localparam int W_RP  = $clog2(TRP + 2);
    localparam int W_CCD = $clog2(TCCD + 2);
    localparam int W_RFC = $clog2(TRFC + 2);

    // Timers are loaded with T-1 on the pin edge and a waiting command may
    // enter ISSUE once its timers reach <= 1: ISSUE itself takes one more
    // cycle, so consecutive pin cycles end up exactly T cycles apart.
    localparam logic [W_RCD-1:0] LD_RCD = W_RCD'((TRCD > 1) ? TRCD - 1 : 0);
    localparam logic [W_RAS-1:0] LD_RAS = W_RAS'((TRAS > 1) ? TRAS - 1 : 0);
    localparam logic [W_RP-1:0]  LD_RP  = W_RP'((TRP > 1) ? TRP - 1 : 0);
    localparam logic [W_CCD-1:0] LD_CCD = W_CCD'((TCCD > 1) ? TCCD - 1 : 0);
    localparam logic [W_RFC-1:0] LD_RFC = W_RFC'((TRFC > 1) ? TRFC - 1 : 0);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cmd_q;
    logic [BGWIDTH-1:0]   req_bg_q;
    logic [BAWIDTH-1:0]   req_ba_q;
    logic [ADDRWIDTH-1:0] req_addr_q;
    logic [NBANKS-1:0]    open_q, open_d;

    logic [W_RCD-1:0] rcd_q, rcd_d;
    logic [W_RAS-1:0] ras_q, ras_d;
    logic [W_RP-1:0]  rp_q,  rp_d;
    logic [W_CCD-1:0] ccd_q, ccd_d;
    logic [W_RFC-1:0] rfc_q, rfc_d;

    logic                 act_n_q, act_n_d;
    logic                 cs_n_q, cs_n_d;
    logic                 cke_q;
    logic [BGWIDTH-1:0]   bg_q, bg_d;
    logic [BAWIDTH-1:0]   ba_q, ba_d;
    logic [ADDRWIDTH-1:0] a_q, a_d;
    logic                 err_q, err_d;

    logic [BKW-1:0]       bank_idx;
    logic                 bank_open;
    logic                 reject;
    logic                 blocked;
    logic                 is_col;
    logic [3:0]           pin_code;
    logic [ADDRWIDTH-1:0] cmd_word;
    logic                 rcd_ok, ras_ok, rp_ok, ccd_ok, rfc_ok;

    assign bank_idx  = {req_bg_q, req_ba_q};
    assign bank_open = open_q[bank_idx];
    assign is_col    = (cmd_q == CMD_RD) || (cmd_q == CMD_RDA) ||
                       (cmd_q == CMD_WR) || (cmd_q == CMD_WRA);

    assign rcd_ok = (rcd_q <= W_RCD'(1));
    assign ras_ok = (ras_q <= W_RAS'(1));
    assign rp_ok  = (rp_q  <= W_RP'(1));
    assign ccd_ok = (ccd_q <= W_CCD'(1));
    assign rfc_ok = (rfc_q <= W_RFC'(1));

    always_comb begin
        reject = 1'b0;
        case (cmd_q)
            CMD_ACT:                         reject = bank_open;
            CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: reject = !bank_open;
            CMD_PR, CMD_PRA:                 reject = 1'b0;
            CMD_REF:                         reject = |open_q;
            default:                         reject = 1'b1;
        endcase
    end

    always_comb begin
        blocked = 1'b0;
        case (cmd_q)
            CMD_ACT, CMD_REF:                blocked = !(rp_ok && rfc_ok);
            CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: blocked = !(rcd_ok && ccd_ok && rfc_ok);
            CMD_PR, CMD_PRA:                 blocked = !(ras_ok && rfc_ok);
            default:                         blocked = 1'b0;
        endcase
    end

    // {RAS_n, CAS_n, WE_n, AP} for the non-ACT commands.
    always_comb begin
        pin_code = 4'b0000;
        case (cmd_q)
            CMD_PR:  pin_code = 4'b0100;
            CMD_PRA: pin_code = 4'b0101;
            CMD_RD:  pin_code = 4'b1010;
            CMD_RDA: pin_code = 4'b1011;
            CMD_WR:  pin_code = 4'b1000;
            CMD_WRA: pin_code = 4'b1001;
            CMD_REF: pin_code = 4'b0010;
            default: pin_code = 4'b0000;
        endcase
        cmd_word = '0;
        cmd_word[ADDRWIDTH-1 -: 4] = pin_code;
        if (is_col) begin
            cmd_word[COLWIDTH-1:0] = req_addr_q[COLWIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        open_d  = open_q;
        rcd_d   = (rcd_q != '0) ? rcd_q - W_RCD'(1) : rcd_q;
        ras_d   = (ras_q != '0) ? ras_q - W_RAS'(1) : ras_q;
        rp_d    = (rp_q  != '0) ? rp_q  - W_RP'(1)  : rp_q;
        ccd_d   = (ccd_q != '0) ? ccd_q - W_CCD'(1) : ccd_q;
        rfc_d   = (rfc_q != '0) ? rfc_q - W_RFC'(1) : rfc_q;
        act_n_d = 1'b1;
        cs_n_d  = 1'b1;
        bg_d    = '0;
        ba_d    = '0;
        a_d     = '1;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!blocked) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // Pins, timers and bank state all update on the edge leaving
                // ISSUE, so a reset during ISSUE emits nothing.
                state_d = S_IDLE;
                cs_n_d  = 1'b0;
                bg_d    = req_bg_q;
                ba_d    = req_ba_q;
                a_d     = cmd_word;
                case (cmd_q)
                    CMD_ACT: begin
                        act_n_d          = 1'b0;
                        a_d              = req_addr_q;
                        rcd_d            = LD_RCD;
                        ras_d            = LD_RAS;
                        open_d[bank_idx] = 1'b1;
                    end
                    CMD_RD, CMD_WR: ccd_d = LD_CCD;
                    CMD_RDA, CMD_WRA: begin
                        ccd_d            = LD_CCD;
                        rp_d             = LD_RP;
                        open_d[bank_idx] = 1'b0;
                    end
                    CMD_PR: begin
                        rp_d             = LD_RP;
                        open_d[bank_idx] = 1'b0;
                    end
                    CMD_PRA: begin
                        rp_d   = LD_RP;
                        open_d = '0;
                    end
                    CMD_REF: rfc_d = LD_RFC;
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            req_bg_q   <= '0;
            req_ba_q   <= '0;
            req_addr_q <= '0;
            open_q     <= '0;
            rcd_q      <= '0;
            ras_q      <= '0;
            rp_q       <= '0;
            ccd_q      <= '0;
            rfc_q      <= '0;
            act_n_q    <= 1'b1;
            cs_n_q     <= 1'b1;
            cke_q      <= 1'b0;
            bg_q       <= '0;
            ba_q       <= '0;
            a_q        <= '1;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid && req_ready) begin
                cmd_q      <= req_cmd;
                req_bg_q   <= req_bg;
                req_ba_q   <= req_ba;
                req_addr_q <= req_addr;
            end
            open_q  <= open_d;
            rcd_q   <= rcd_d;
            ras_q   <= ras_d;
            rp_q    <= rp_d;
            ccd_q   <= ccd_d;
            rfc_q   <= rfc_d;
            act_n_q <= act_n_d;
            cs_n_q  <= cs_n_d;
            cke_q   <= 1'b1;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            err_q   <= err_d;
        end
    end

    // cke_q doubles as "first edge after reset release has happened".
    assign req_ready = cke_q && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign act_n     = act_n_q;
    assign cs_n      = cs_n_q;
    assign cke       = cke_q;
    assign bg        = bg_q;
    assign ba        = ba_q;
    assign A         = a_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// Bench for ddr_cmd_encoder: expected command pins are queued as requests
// are driven and compared by a monitor whenever cs_n goes low; each scenario
// task checks its own latency, gap and error-pulse expectations.
module tb_ddr_cmd_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = '0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_addr = '0;
    logic        act_n, cs_n, cke, err, busy;
    logic [1:0]  bg, ba;
    logic [16:0] A;

    typedef struct {
        logic        act_n;
        logic [16:0] a;
        logic [1:0]  bg;
        logic [1:0]  ba;
    } exp_t;

    exp_t q[$];
    int   issued[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   prev_issue = 0;

    ddr_cmd_encoder #(
        .ADDRWIDTH(17), .COLWIDTH(10), .BGWIDTH(2), .BAWIDTH(2),
        .TRCD(16), .TRAS(39), .TRP(16), .TCCD(4), .TRFC(260)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_bg(req_bg), .req_ba(req_ba), .req_addr(req_addr),
        .act_n(act_n), .cs_n(cs_n), .cke(cke), .bg(bg), .ba(ba), .A(A),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t mk(input logic [3:0] c, input logic [1:0] g,
                                input logic [1:0] b, input logic [16:0] ad);
        exp_t e;
        e.bg = g; e.ba = b; e.act_n = 1'b1; e.a = '0;
        case (c)
            4'd1: begin e.act_n = 1'b0; e.a = ad; end
            4'd2: e.a = {4'b1010, 3'b000, ad[9:0]};
            4'd3: e.a = {4'b1011, 3'b000, ad[9:0]};
            4'd4: e.a = {4'b1000, 3'b000, ad[9:0]};
            4'd5: e.a = {4'b1001, 3'b000, ad[9:0]};
            4'd6: e.a = {4'b0100, 13'b0};
            4'd7: e.a = {4'b0101, 13'b0};
            4'd8: e.a = {4'b0010, 13'b0};
            default: e.a = '1;
        endcase
        return e;
    endfunction

    // Pin monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (prev_issue) begin
            total++;
            if (cs_n !== 1'b1 || act_n !== 1'b1 || A !== 17'h1FFFF) begin
                bad++;
                $display("FAIL idle_after_issue: cs_n=%b act_n=%b A=%h, need 1 1 1ffff", cs_n, act_n, A);
            end
        end
        prev_issue = 0;
        if (cs_n === 1'b0) begin
            prev_issue = 1;
            issued.push_back(cyc);
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue at cycle %0d: act_n=%b A=%h", cyc, act_n, A);
            end else begin
                e = q.pop_front();
                if (act_n !== e.act_n || A !== e.a || bg !== e.bg || ba !== e.ba || cke !== 1'b1) begin
                    bad++;
                    $display("FAIL issue_pins: act_n=%b A=%h bg=%0d ba=%0d cke=%b, need act_n=%b A=%h bg=%0d ba=%0d cke=1",
                             act_n, A, bg, ba, cke, e.act_n, e.a, e.bg, e.ba);
                end
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [1:0] g, input logic [1:0] b,
                        input logic [16:0] ad, input bit exp_issue, output int acc);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_ready: req_ready=%b after %0d cycles, need 1", req_ready, n);
        end
        req_valid = 1'b1; req_cmd = c; req_bg = g; req_ba = b; req_addr = ad;
        if (exp_issue) q.push_back(mk(c, g, b, ad));
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_issues(input int target, input string nm);
        int n = 0;
        while (issued.size() < target && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (issued.size() < target) begin
            bad++;
            $display("FAIL %s timeout: issued=%0d, need %0d", nm, issued.size(), target);
        end
    endtask

    task automatic expect_err(input string nm);
        @(posedge clk); #1;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL %s err_pulse: err=%b, need 1", nm, err);
        end
        @(posedge clk); #1;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL %s err_clear: err=%b, need 0", nm, err);
        end
    endtask

    task automatic check_gap(input string nm, input int got, input int need, input bit exact);
        total++;
        if (exact ? (got != need) : (got < need)) begin
            bad++;
            $display("FAIL %s: gap=%0d, need %s%0d", nm, got, exact ? "" : ">=", need);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        total++;
        if ({act_n, cs_n, cke, err, busy, req_ready} !== 6'b110000 ||
            A !== 17'h1FFFF || bg !== 2'd0 || ba !== 2'd0) begin
            bad++;
            $display("FAIL %s: act_n,cs_n,cke,err,busy,ready=%b A=%h bg=%0d ba=%0d, need 110000 1ffff 0 0",
                     nm, {act_n, cs_n, cke, err, busy, req_ready}, A, bg, ba);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (cke !== 1'b1 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL cke_rise: cke=%b req_ready=%b, need 1 1", cke, req_ready);
        end
    endtask

    task automatic test_act();
        int base, acc;
        base = issued.size();
        send(4'd1, 2'd1, 2'd2, 17'h1ABC, 1, acc);
        wait_issues(base + 1, "act");
        check_gap("act_latency", issued[base] - acc, 3, 1);
        send(4'd1, 2'd1, 2'd2, 17'h0001, 0, acc);
        expect_err("act_open_bank6");
    endtask

    task automatic test_rd_after_act();
        int base, a1, a2;
        base = issued.size();
        send(4'd1, 2'd0, 2'd0, 17'h0123, 1, a1);
        send(4'd2, 2'd0, 2'd0, 17'h0055, 1, a2);
        wait_issues(base + 2, "rd_after_act");
        check_gap("trcd_gap", issued[base + 1] - issued[base], 16, 1);
    endtask

    task automatic test_back_to_back();
        int base, acc;
        base = issued.size();
        send(4'd2, 2'd0, 2'd0, 17'h00AA, 1, acc);
        send(4'd5, 2'd0, 2'd0, 17'h0155, 1, acc);
        wait_issues(base + 2, "rd_wra");
        check_gap("tccd_gap", issued[base + 1] - issued[base], 4, 1);
        send(4'd2, 2'd0, 2'd0, 17'h0011, 0, acc);
        expect_err("rd_after_wra_closed");
        send(4'd1, 2'd0, 2'd0, 17'h0777, 1, acc);
        wait_issues(base + 3, "act_after_wra");
        check_gap("trp_after_wra", issued[base + 2] - issued[base + 1], 16, 0);
    endtask

    task automatic test_reject();
        int base, acc;
        base = issued.size();
        send(4'd2, 2'd0, 2'd3, 17'h0010, 0, acc);
        expect_err("rd_closed_bank3");
        send(4'd8, 2'd0, 2'd0, 17'h0000, 0, acc);
        expect_err("ref_bank_open");
        send(4'd0, 2'd0, 2'd0, 17'h0000, 0, acc);
        expect_err("illegal_cmd0");
        send(4'd9, 2'd1, 2'd1, 17'h0000, 0, acc);
        expect_err("illegal_cmd9");
        repeat (5) @(negedge clk);
        total++;
        if (issued.size() != base) begin
            bad++;
            $display("FAIL reject_no_issue: issued=%0d, need %0d", issued.size(), base);
        end
    endtask

    task automatic test_pra_ref();
        int base, acc;
        base = issued.size();
        send(4'd1, 2'd0, 2'd3, 17'h0F0F, 1, acc);
        send(4'd7, 2'd0, 2'd0, 17'h0000, 1, acc);
        wait_issues(base + 2, "pra");
        check_gap("tras_gap", issued[base + 1] - issued[base], 39, 0);
        send(4'd8, 2'd0, 2'd0, 17'h0000, 1, acc);
        wait_issues(base + 3, "ref");
        check_gap("trp_before_ref", issued[base + 2] - issued[base + 1], 16, 1);
        send(4'd1, 2'd1, 2'd1, 17'h0321, 1, acc);
        wait_issues(base + 4, "act_after_ref");
        check_gap("trfc_gap", issued[base + 3] - issued[base + 2], 260, 0);
        send(4'd6, 2'd1, 2'd0, 17'h0000, 1, acc);
        wait_issues(base + 5, "pr_closed_bank");
        check_gap("tras_pr_gap", issued[base + 4] - issued[base + 3], 39, 0);
    endtask

    task automatic test_reset_mid_wait();
        int base, acc;
        base = issued.size();
        send(4'd1, 2'd0, 2'd2, 17'h0456, 1, acc);
        wait_issues(base + 1, "act_before_reset");
        send(4'd6, 2'd0, 2'd2, 17'h0000, 1, acc);
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL pr_waiting_busy: busy=%b, need 1", busy);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset_mid_wait");
        repeat (3) @(negedge clk);
        q.delete();
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        total++;
        if (issued.size() != base + 1) begin
            bad++;
            $display("FAIL pr_dropped_by_reset: issued=%0d, need %0d", issued.size(), base + 1);
        end
        send(4'd2, 2'd0, 2'd2, 17'h0010, 0, acc);
        expect_err("bank_closed_after_reset");
        send(4'd1, 2'd0, 2'd2, 17'h0456, 1, acc);
        wait_issues(base + 2, "act_after_reset");
        check_gap("act_latency_after_reset", issued[base + 1] - acc, 3, 1);
    endtask

    initial begin
        test_reset();
        test_act();
        test_rd_after_act();
        test_back_to_back();
        test_reject();
        test_pra_ref();
        test_reset_mid_wait();
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: %0d commands never issued", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
